mcu_quantize_scheduler: RTL and testbench

Sequences quantization of DCT output groups through the single shared pipelined divider. It tracks which DCT output buffer slots hold finished 5-block MCU groups and walks their coefficients in zig-zag order. It issues one divider request per cycle and tracks occupancy of the quotient output buffer. It also starts the Huffman encoder on each completed quotient slot. It sits between the DCT output EBRs / DCT manager and the divider / quotient EBR / Huffman encoder, and replaces the inline quantizer FSM and encoder-start logic.

---
 rtl/mcu_quantize_scheduler_pkg.sv | 31 +++
 rtl/zig_zag_to_row_major.sv | 29 ++
 rtl/mcu_quantize_scheduler.sv | 159 +++++++++++++++
 tb/tb_mcu_quantize_scheduler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_quantize_scheduler_pkg.sv
// rtl/mcu_quantize_scheduler_pkg.sv - shared widths, tag layout and FSM encoding for the quantize scheduler
package mcu_quantize_scheduler_pkg;

  localparam int NUM_BLOCKS = 5;
  localparam int IN_SLOTS   = 4;
  localparam int OUT_SLOTS  = 4;

  localparam int SLOT_W  = $clog2(IN_SLOTS);
  localparam int OSLOT_W = $clog2(OUT_SLOTS);
  localparam int ZZ_W    = 6;
  localparam int TAG_W   = OSLOT_W + ZZ_W;
  localparam int CNT_W   = 3;
  localparam int BLK_W   = 3;

  localparam int TAG_IDX_LSB  = 0;
  localparam int TAG_IDX_MSB  = ZZ_W - 1;
  localparam int TAG_SLOT_LSB = ZZ_W;
  localparam int TAG_SLOT_MSB = TAG_W - 1;

  localparam logic [CNT_W-1:0] IN_FULL    = CNT_W'(IN_SLOTS);
  localparam logic [CNT_W-1:0] OUT_FULL   = CNT_W'(OUT_SLOTS);
  localparam logic [BLK_W-1:0] LAST_BLOCK = BLK_W'(NUM_BLOCKS - 1);
  localparam logic [ZZ_W-1:0]  LAST_ZZ    = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_STALL
  } state_t;

endpackage

// File: rtl/zig_zag_to_row_major.sv
// rtl/zig_zag_to_row_major.sv - maps an 8x8 zig-zag coefficient index to its row-major position
module zig_zag_to_row_major (
  input  logic [5:0] zz_index,
  output logic [5:0] row_major
);

  always_comb begin
    row_major = 6'd0;
    case (zz_index)
      6'd0:  row_major = 6'd0;   6'd1:  row_major = 6'd1;   6'd2:  row_major = 6'd8;   6'd3:  row_major = 6'd16;
      6'd4:  row_major = 6'd9;   6'd5:  row_major = 6'd2;   6'd6:  row_major = 6'd3;   6'd7:  row_major = 6'd10;
      6'd8:  row_major = 6'd17;  6'd9:  row_major = 6'd24;  6'd10: row_major = 6'd32;  6'd11: row_major = 6'd25;
      6'd12: row_major = 6'd18;  6'd13: row_major = 6'd11;  6'd14: row_major = 6'd4;   6'd15: row_major = 6'd5;
      6'd16: row_major = 6'd12;  6'd17: row_major = 6'd19;  6'd18: row_major = 6'd26;  6'd19: row_major = 6'd33;
      6'd20: row_major = 6'd40;  6'd21: row_major = 6'd48;  6'd22: row_major = 6'd41;  6'd23: row_major = 6'd34;
      6'd24: row_major = 6'd27;  6'd25: row_major = 6'd20;  6'd26: row_major = 6'd13;  6'd27: row_major = 6'd6;
      6'd28: row_major = 6'd7;   6'd29: row_major = 6'd14;  6'd30: row_major = 6'd21;  6'd31: row_major = 6'd28;
      6'd32: row_major = 6'd35;  6'd33: row_major = 6'd42;  6'd34: row_major = 6'd49;  6'd35: row_major = 6'd56;
      6'd36: row_major = 6'd57;  6'd37: row_major = 6'd50;  6'd38: row_major = 6'd43;  6'd39: row_major = 6'd36;
      6'd40: row_major = 6'd29;  6'd41: row_major = 6'd22;  6'd42: row_major = 6'd15;  6'd43: row_major = 6'd23;
      6'd44: row_major = 6'd30;  6'd45: row_major = 6'd37;  6'd46: row_major = 6'd44;  6'd47: row_major = 6'd51;
      6'd48: row_major = 6'd58;  6'd49: row_major = 6'd59;  6'd50: row_major = 6'd52;  6'd51: row_major = 6'd45;
      6'd52: row_major = 6'd38;  6'd53: row_major = 6'd31;  6'd54: row_major = 6'd39;  6'd55: row_major = 6'd46;
      6'd56: row_major = 6'd53;  6'd57: row_major = 6'd60;  6'd58: row_major = 6'd61;  6'd59: row_major = 6'd54;
      6'd60: row_major = 6'd47;  6'd61: row_major = 6'd55;  6'd62: row_major = 6'd62;  6'd63: row_major = 6'd63;
    endcase
  end

endmodule

// File: rtl/mcu_quantize_scheduler.sv
// rtl/mcu_quantize_scheduler.sv - walks held DCT groups through the shared divider and hands finished quotient slots to the encoder
module mcu_quantize_scheduler
  import mcu_quantize_scheduler_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      dct_group_done,
  output logic                      dct_slots_free,
  output logic [SLOT_W+ZZ_W-1:0]    rd_addr,
  output logic [ZZ_W-1:0]           qtab_addr,
  output logic [BLK_W-1:0]          rd_block_sel,
  output logic                      div_valid,
  output logic [TAG_W-1:0]          div_tag,
  input  logic                      quot_valid,
  input  logic [TAG_W-1:0]          quot_tag,
  output logic                      enc_start,
  output logic [OSLOT_W-1:0]        enc_slot,
  input  logic                      enc_block_done,
  output logic                      protocol_error
);

  state_t state_q, state_d;
  logic [ZZ_W-1:0]    zz_q, zz_d;
  logic [BLK_W-1:0]   block_q, block_d;
  logic [SLOT_W-1:0]  rd_slot_q, rd_slot_d;
  logic [OSLOT_W-1:0] out_slot_q, out_slot_d;
  logic [OSLOT_W-1:0] comp_slot_q, comp_slot_d;
  logic [OSLOT_W-1:0] enc_slot_q, enc_slot_d;
  logic [CNT_W-1:0]   in_count_q, in_count_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic [CNT_W-1:0]   ready_count_q, ready_count_d;
  logic               div_valid_q, div_valid_d;
  logic [TAG_W-1:0]   div_tag_q, div_tag_d;
  logic [BLK_W-1:0]   rd_block_sel_q, rd_block_sel_d;
  logic               enc_start_q, enc_start_d;
  logic               enc_busy_q, enc_busy_d;
  logic               armed_q, armed_d;
  logic               protocol_error_q, protocol_error_d;

  logic [ZZ_W-1:0] row_major;
  logic issuing, last_coef, group_end, in_full, out_free;
  logic group_in, slot_release, slot_complete, enc_go;

  zig_zag_to_row_major u_zig_zag (
    .zz_index  (zz_q),
    .row_major (row_major)
  );

  assign issuing       = (state_q == ST_ISSUE);
  assign last_coef     = issuing && (zz_q == LAST_ZZ);
  assign group_end     = last_coef && (block_q == LAST_BLOCK);
  assign in_full       = (in_count_q == IN_FULL);
  assign out_free      = (out_count_q != OUT_FULL);
  assign group_in      = dct_group_done && !in_full;
  assign slot_release  = enc_block_done && enc_busy_q;
  // Stale divider results from before a reset are dropped until this run has issued something.
  assign slot_complete = quot_valid && armed_q && (quot_tag[TAG_IDX_MSB:TAG_IDX_LSB] == LAST_ZZ);
  assign enc_go        = ((ready_count_q != '0) || slot_complete) && !enc_busy_q;

  always_comb begin
    in_count_d    = in_count_q + CNT_W'(group_in) - CNT_W'(group_end);
    out_count_d   = out_count_q + CNT_W'(issuing && (zz_q == '0)) - CNT_W'(slot_release);
    ready_count_d = ready_count_q + CNT_W'(slot_complete) - CNT_W'(enc_go);
    enc_busy_d    = enc_go || (enc_busy_q && !slot_release);
    enc_start_d   = enc_go;
    enc_slot_d    = enc_slot_q + OSLOT_W'(slot_release);
    comp_slot_d   = comp_slot_q + OSLOT_W'(slot_complete);
    armed_d       = armed_q || div_valid_q;
    protocol_error_d = protocol_error_q
                     || (dct_group_done && in_full)
                     || (slot_complete && (quot_tag[TAG_SLOT_MSB:TAG_SLOT_LSB] != comp_slot_q))
                     || (enc_block_done && !enc_busy_q);

    div_valid_d    = issuing;
    div_tag_d      = {out_slot_q, zz_q};
    rd_block_sel_d = block_q;

    zz_d       = issuing ? zz_q + ZZ_W'(1) : zz_q;
    block_d    = block_q;
    out_slot_d = out_slot_q;
    rd_slot_d  = rd_slot_q;
    if (last_coef) begin
      out_slot_d = out_slot_q + OSLOT_W'(1);
      block_d    = group_end ? '0 : block_q + BLK_W'(1);
    end
    if (group_end) begin
      rd_slot_d = rd_slot_q + SLOT_W'(1);
    end

    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if ((in_count_d != '0) && out_free) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (last_coef) begin
          if (group_end && (in_count_d == '0)) state_d = ST_IDLE;
          else if (!out_free)                  state_d = ST_STALL;
          else                                 state_d = ST_ISSUE;
        end
      end
      ST_STALL: begin
        if (out_free) state_d = ST_ISSUE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      zz_q             <= '0;
      block_q          <= '0;
      rd_slot_q        <= '0;
      out_slot_q       <= '0;
      comp_slot_q      <= '0;
      enc_slot_q       <= '0;
      in_count_q       <= '0;
      out_count_q      <= '0;
      ready_count_q    <= '0;
      div_valid_q      <= 1'b0;
      div_tag_q        <= '0;
      rd_block_sel_q   <= '0;
      enc_start_q      <= 1'b0;
      enc_busy_q       <= 1'b0;
      armed_q          <= 1'b0;
      protocol_error_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      zz_q             <= zz_d;
      block_q          <= block_d;
      rd_slot_q        <= rd_slot_d;
      out_slot_q       <= out_slot_d;
      comp_slot_q      <= comp_slot_d;
      enc_slot_q       <= enc_slot_d;
      in_count_q       <= in_count_d;
      out_count_q      <= out_count_d;
      ready_count_q    <= ready_count_d;
      div_valid_q      <= div_valid_d;
      div_tag_q        <= div_tag_d;
      rd_block_sel_q   <= rd_block_sel_d;
      enc_start_q      <= enc_start_d;
      enc_busy_q       <= enc_busy_d;
      armed_q          <= armed_d;
      protocol_error_q <= protocol_error_d;
    end
  end

  assign dct_slots_free = !in_full;
  assign rd_addr        = {rd_slot_q, row_major};
  assign qtab_addr      = zz_q;
  assign rd_block_sel   = rd_block_sel_q;
  assign div_valid      = div_valid_q;
  assign div_tag        = div_tag_q;
  assign enc_start      = enc_start_q;
  assign enc_slot       = enc_slot_q;
  assign protocol_error = protocol_error_q;

endmodule

// File: tb/tb_mcu_quantize_scheduler.sv
// tb/tb_mcu_quantize_scheduler.sv - directed self-checking bench for mcu_quantize_scheduler
module tb_mcu_quantize_scheduler;

  logic       clock;
  logic       reset;
  logic       dct_group_done;
  logic       dct_slots_free;
  logic [7:0] rd_addr;
  logic [5:0] qtab_addr;
  logic [2:0] rd_block_sel;
  logic       div_valid;
  logic [7:0] div_tag;
  logic       quot_valid;
  logic [7:0] quot_tag;
  logic       enc_start;
  logic [1:0] enc_slot;
  logic       enc_block_done;
  logic       protocol_error;

  int checks = 0;
  int failures = 0;
  logic [5:0] zz_exp [6] = '{6'd0, 6'd1, 6'd8, 6'd16, 6'd9, 6'd2};

  mcu_quantize_scheduler dut (
    .clock          (clock),
    .reset          (reset),
    .dct_group_done (dct_group_done),
    .dct_slots_free (dct_slots_free),
    .rd_addr        (rd_addr),
    .qtab_addr      (qtab_addr),
    .rd_block_sel   (rd_block_sel),
    .div_valid      (div_valid),
    .div_tag        (div_tag),
    .quot_valid     (quot_valid),
    .quot_tag       (quot_tag),
    .enc_start      (enc_start),
    .enc_slot       (enc_slot),
    .enc_block_done (enc_block_done),
    .protocol_error (protocol_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic pulse_group();
    dct_group_done = 1'b1;
    step();
    dct_group_done = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int dv;
    int starts;

    reset = 1'b1;
    dct_group_done = 1'b0;
    quot_valid = 1'b0;
    quot_tag = 8'h00;
    enc_block_done = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    chk("reset_div_valid", 32'(div_valid), 0);
    chk("reset_div_tag", 32'(div_tag), 0);
    chk("reset_rd_addr", 32'(rd_addr), 0);
    chk("reset_qtab_addr", 32'(qtab_addr), 0);
    chk("reset_rd_block_sel", 32'(rd_block_sel), 0);
    chk("reset_enc_start", 32'(enc_start), 0);
    chk("reset_enc_slot", 32'(enc_slot), 0);
    chk("reset_protocol_error", 32'(protocol_error), 0);
    chk("reset_slots_free", 32'(dct_slots_free), 1);

    dv = 0;
    repeat (100) begin
      step();
      if (div_valid) dv++;
    end
    chk("idle_no_div_valid", dv, 0);

    // One group, encoder never releases: zig-zag order, tags, then stall after four blocks.
    pulse_group();
    dv = 0;
    for (int n = 0; n < 300; n++) begin
      if (n < 6) begin
        chk("zz_rd_addr", 32'({2'b00, zz_exp[n]}) ^ 32'(rd_addr) ^ 32'({2'b00, zz_exp[n]}), 32'({2'b00, zz_exp[n]}));
        chk("zz_qtab_addr", 32'(qtab_addr), 32'(n[5:0]));
      end
      if (n == 0) chk("first_div_latency", 32'(div_valid), 0);
      if (div_valid) begin
        if (dv < 128) begin
          chk("div_tag_seq", 32'(div_tag), 32'(dv[7:0]));
          chk("rd_block_sel_seq", 32'(rd_block_sel), dv / 64);
        end
        dv++;
      end
      step();
    end
    chk("backpressure_div_count", dv, 256);
    chk("stall_div_valid", 32'(div_valid), 0);

    quot_valid = 1'b1;
    quot_tag = 8'h3F;
    step();
    quot_valid = 1'b0;
    chk("enc_start_slot0", 32'(enc_start), 1);
    chk("enc_slot_first", 32'(enc_slot), 0);
    step();
    chk("enc_start_one_cycle", 32'(enc_start), 0);

    quot_valid = 1'b1;
    quot_tag = 8'h7F;
    step();
    quot_valid = 1'b0;
    starts = 0;
    repeat (4) begin
      if (enc_start) starts++;
      step();
    end
    chk("enc_start_deferred", starts, 0);
    chk("still_stalled", 32'(div_valid), 0);
    chk("no_error_before_release", 32'(protocol_error), 0);

    enc_block_done = 1'b1;
    step();
    enc_block_done = 1'b0;
    chk("enc_slot_advanced", 32'(enc_slot), 1);
    chk("enc_start_after_release_wait", 32'(enc_start), 0);
    step();
    chk("enc_start_slot1", 32'(enc_start), 1);
    chk("enc_slot_second", 32'(enc_slot), 1);

    dv = 0;
    for (int n = 0; n < 100; n++) begin
      if (div_valid) begin
        chk("block4_tag", 32'(div_tag), 32'(dv[7:0]));
        chk("block4_block_sel", 32'(rd_block_sel), 4);
        dv++;
      end
      step();
    end
    chk("block4_div_count", dv, 64);
    chk("group_done_slots_free", 32'(dct_slots_free), 1);
    chk("group_done_no_error", 32'(protocol_error), 0);

    // Input full: out slots are all held, so nothing issues while groups accumulate.
    repeat (3) pulse_group();
    chk("three_groups_free", 32'(dct_slots_free), 1);
    pulse_group();
    chk("four_groups_full", 32'(dct_slots_free), 0);
    chk("four_groups_no_error", 32'(protocol_error), 0);
    chk("full_no_issue", 32'(div_valid), 0);
    pulse_group();
    chk("overflow_error", 32'(protocol_error), 1);

    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrun_reset_error", 32'(protocol_error), 0);
    chk("midrun_reset_free", 32'(dct_slots_free), 1);
    chk("midrun_reset_enc_slot", 32'(enc_slot), 0);
    chk("midrun_reset_rd_addr", 32'(rd_addr), 0);
    chk("midrun_reset_div_valid", 32'(div_valid), 0);

    quot_valid = 1'b1;
    quot_tag = 8'hFF;
    step();
    quot_valid = 1'b0;
    chk("stale_quot_no_start", 32'(enc_start), 0);
    chk("stale_quot_no_error", 32'(protocol_error), 0);

    // Back-to-back groups: second dct_group_done lands on the last coefficient of the first.
    pulse_group();
    dv = 0;
    for (int n = 0; n < 340; n++) begin
      if (n == 11) begin
        chk("b2b_enc_start", 32'(enc_start), 1);
        chk("b2b_enc_slot0", 32'(enc_slot), 0);
      end
      if (n == 80) chk("b2b_enc_slot2", 32'(enc_slot), 2);
      if (n == 320) begin
        chk("b2b_next_rd_addr", 32'(rd_addr), 32'h40);
        chk("b2b_last_div_valid", 32'(div_valid), 1);
        chk("b2b_last_block_sel", 32'(rd_block_sel), 4);
        chk("b2b_last_tag", 32'(div_tag), 32'h3F);
      end
      if (n == 321) begin
        chk("b2b_first_div_valid", 32'(div_valid), 1);
        chk("b2b_first_block_sel", 32'(rd_block_sel), 0);
        chk("b2b_first_tag", 32'(div_tag), 32'h40);
        chk("b2b_slots_free", 32'(dct_slots_free), 1);
      end
      if (div_valid && n <= 321) dv++;
      quot_valid = (n == 10) || (n == 70);
      quot_tag = (n == 70) ? 8'h7F : 8'h3F;
      enc_block_done = (n == 14) || (n == 74);
      dct_group_done = (n == 319);
      step();
    end
    quot_valid = 1'b0;
    enc_block_done = 1'b0;
    dct_group_done = 1'b0;
    chk("b2b_no_bubble", dv, 321);
    chk("b2b_no_error", 32'(protocol_error), 0);

    enc_block_done = 1'b1;
    step();
    enc_block_done = 1'b0;
    chk("spurious_release_error", 32'(protocol_error), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
